// File: rtl/round_robin_quantum_arbiter_pkg.sv
// rtl/round_robin_quantum_arbiter_pkg.sv - shared types and widths for the quantum arbiter
package round_robin_quantum_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;
    localparam int CNT_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/round_robin_quantum_arbiter_if.sv
// rtl/round_robin_quantum_arbiter_if.sv - request/grant bundle between requesters and arbiter
interface round_robin_quantum_arbiter_if;
    import round_robin_quantum_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_id;
    logic               busy;
    logic [CNT_W-1:0]   slot_cnt;

    modport master (output req, input gnt, input gnt_id, input busy, input slot_cnt);
    modport slave  (input req, output gnt, output gnt_id, output busy, output slot_cnt);
endinterface

// File: rtl/round_robin_quantum_arbiter_rr_pick.sv
// rtl/round_robin_quantum_arbiter_rr_pick.sv - first set request bit at or after start, wrapping
module rr_pick
    import round_robin_quantum_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic               found,
    output logic [PTR_W-1:0]   idx
);

    logic [PTR_W-1:0] cand;

    // Walk from the farthest offset down so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start + PTR_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/round_robin_quantum_arbiter.sv
// rtl/round_robin_quantum_arbiter.sv - round-robin arbiter with per-owner grant quantum
module round_robin_quantum_arbiter
    import round_robin_quantum_arbiter_pkg::*;
#(
    parameter int QUANTUM = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    round_robin_quantum_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] pick_req;
    logic [PTR_W-1:0]   pick_start;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    assign owner_onehot = NUM_REQ'(1) << owner_q;
    // While granted the owner sits at the end of the search order; masking it
    // makes "found" mean "someone else is waiting".
    assign pick_req     = (state_q == ST_GRANT) ? (bus.req & ~owner_onehot) : bus.req;
    assign pick_start   = last_q + PTR_W'(1);

    rr_pick u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = ST_GRANT;
                owner_d = pick_idx;
                last_d  = pick_idx;
                cnt_d   = CNT_W'(1);
            end
        end else begin
            if (!bus.req[owner_q] || (cnt_q >= QMAX)) begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = CNT_W'(1);
                end else if (bus.req[owner_q]) begin
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.busy     = (state_q == ST_GRANT);
    assign bus.gnt      = bus.busy ? owner_onehot : '0;
    assign bus.gnt_id   = bus.busy ? owner_q : '0;
    assign bus.slot_cnt = cnt_q;

endmodule

// File: tb/tb_round_robin_quantum_arbiter.sv
// tb/tb_round_robin_quantum_arbiter.sv - directed and random checks, QUANTUM=4 and QUANTUM=1 instances
module tb_round_robin_quantum_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    integer checks = 0;
    integer failures = 0;

    round_robin_quantum_arbiter_if bus_a ();
    round_robin_quantum_arbiter_if bus_b ();

    round_robin_quantum_arbiter #(.QUANTUM(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    round_robin_quantum_arbiter #(.QUANTUM(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] v);
        bus_a.req = v;
        bus_b.req = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_req(4'b0000);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                           input logic b, input logic [3:0] s);
        check({tag, ".gnt"},      32'(bus_a.gnt),      32'(g));
        check({tag, ".gnt_id"},   32'(bus_a.gnt_id),   32'(id));
        check({tag, ".busy"},     32'(bus_a.busy),     32'(b));
        check({tag, ".slot_cnt"}, 32'(bus_a.slot_cnt), 32'(s));
    endtask

    logic [3:0] r;
    logic [3:0] exp_g;
    int         wa [4];
    int         wb [4];

    initial begin
        set_req(4'b0000);
        #2;
        check_a("reset", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Single requester: quantum reloads when nobody else waits
        apply_reset();
        step();
        check_a("idle_no_req", 4'b0000, 2'd0, 1'b0, 4'd0);
        set_req(4'b0001);
        step();
        check_a("solo_c1", 4'b0001, 2'd0, 1'b1, 4'd1);
        step();
        check_a("solo_c2", 4'b0001, 2'd0, 1'b1, 4'd2);
        step();
        check_a("solo_c3", 4'b0001, 2'd0, 1'b1, 4'd3);
        step();
        check_a("solo_c4", 4'b0001, 2'd0, 1'b1, 4'd4);
        step();
        check_a("solo_reload", 4'b0001, 2'd0, 1'b1, 4'd1);

        // All request: 4-cycle slots on dut_a, 1-cycle rotation on dut_b
        apply_reset();
        set_req(4'b1111);
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_g = 4'b0001 << (((k - 1) / 4) % 4);
            check_a($sformatf("all_a_%0d", k), exp_g, 2'(((k - 1) / 4) % 4), 1'b1, 4'(((k - 1) % 4) + 1));
            check($sformatf("all_b_gnt_%0d", k), 32'(bus_b.gnt), 32'(4'b0001 << ((k - 1) % 4)));
            check($sformatf("all_b_slot_%0d", k), 32'(bus_b.slot_cnt), 32'd1);
        end

        // Owner releases early: hand-off with no idle cycle
        apply_reset();
        set_req(4'b0010);
        step();
        check_a("drop_own1", 4'b0010, 2'd1, 1'b1, 4'd1);
        set_req(4'b0110);
        step();
        check_a("drop_own1_c2", 4'b0010, 2'd1, 1'b1, 4'd2);
        set_req(4'b0100);
        step();
        check_a("drop_handoff", 4'b0100, 2'd2, 1'b1, 4'd1);

        // Owner 3 leaves, idle, then search restarts at 0
        apply_reset();
        set_req(4'b1000);
        step();
        check_a("own3", 4'b1000, 2'd3, 1'b1, 4'd1);
        set_req(4'b0000);
        step();
        check_a("own3_idle", 4'b0000, 2'd0, 1'b0, 4'd0);
        set_req(4'b0011);
        step();
        check_a("after3_pick0", 4'b0001, 2'd0, 1'b1, 4'd1);

        // Pointer held through idle: last=1 so search is 2,3,0,1
        apply_reset();
        set_req(4'b0010);
        step();
        set_req(4'b0000);
        step();
        check_a("hold_idle", 4'b0000, 2'd0, 1'b0, 4'd0);
        set_req(4'b1011);
        step();
        check_a("hold_last1", 4'b1000, 2'd3, 1'b1, 4'd1);

        // Asynchronous reset mid-grant
        apply_reset();
        set_req(4'b1111);
        step();
        step();
        check_a("pre_async", 4'b0001, 2'd0, 1'b1, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 4'b0000, 2'd0, 1'b0, 4'd0);
        #1;
        rst_n = 1'b1;
        step();
        check_a("post_async", 4'b0001, 2'd0, 1'b1, 4'd1);

        // Random requests: one-hot, grant only to a requester, bounded wait
        apply_reset();
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wa[i] = 0;
            wb[i] = 0;
        end
        for (int n = 0; n < 2000; n++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            set_req(r);
            step();
            check("rnd_onehot_a", 32'($onehot0(bus_a.gnt)), 32'd1);
            check("rnd_onehot_b", 32'($onehot0(bus_b.gnt)), 32'd1);
            check("rnd_legal_a", 32'(bus_a.gnt & ~r), 32'd0);
            check("rnd_legal_b", 32'(bus_b.gnt & ~r), 32'd0);
            for (int i = 0; i < 4; i++) begin
                wa[i] = (r[i] && !bus_a.gnt[i]) ? wa[i] + 1 : 0;
                wb[i] = (r[i] && !bus_b.gnt[i]) ? wb[i] + 1 : 0;
                if (wa[i] > 12) check($sformatf("rnd_starve_a%0d", i), 32'(wa[i]), 32'd12);
                if (wb[i] > 3)  check($sformatf("rnd_starve_b%0d", i), 32'(wb[i]), 32'd3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
